writeback_stage: RTL and testbench

- Write-back stage that drives the write port of the 8-entry x 8-bit register bank: RegWrite, EscReg, WriteData.
- Accepts completed instructions from EX/MEM through a valid/ready handshake and buffers them in a small FIFO.
- Selects the ALU result or a variable-latency memory load return as write data, and never writes register 0.
- Tells decode when a read source still has a pending write, so decode can stall.

---
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Write-back stage: buffers completed EX/MEM results in a small in-order FIFO and
// drives the register bank write port, waiting on load returns and flagging decode hazards.
module writeback_stage #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_reg_write,
   input  logic              in_mem_to_reg,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] EscReg,
   output logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] hz_read1,
   input  logic [1:0]        hz_read2,
   output logic              hz_stall
);

   // state    | meaning
   // IDLE     | commit ALU heads directly; a load head moves to WAIT_MEM
   // WAIT_MEM | load head parked until mem_valid supplies its data
   typedef enum logic {IDLE, WAIT_MEM} state_t;

   // DEPTH must be a power of two >= 2 so pointer increments wrap naturally
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] rd_q  [DEPTH];
   logic              rw_q  [DEPTH];
   logic              m2r_q [DEPTH];
   logic [DATA_W-1:0] alu_q [DEPTH];

   state_t            state;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] head_rd;
   logic              head_rw;
   logic              head_m2r;
   logic [DATA_W-1:0] head_alu;
   logic [ADDR_W-1:0] rd2_ext;
   logic [PTR_W-1:0]  hz_off;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;
   assign push     = in_valid && !full;

   assign head_rd  = rd_q[rd_ptr];
   assign head_rw  = rw_q[rd_ptr];
   assign head_m2r = m2r_q[rd_ptr];
   assign head_alu = alu_q[rd_ptr];

   always_comb begin
      pop = 1'b0;
      case (state)
         IDLE:     pop = !empty && !head_m2r;
         WAIT_MEM: pop = mem_valid;
         default:  pop = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) begin
         rd_q[wr_ptr]  <= in_rd;
         rw_q[wr_ptr]  <= in_reg_write;
         m2r_q[wr_ptr] <= in_mem_to_reg;
         alu_q[wr_ptr] <= in_alu_result;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         RegWrite  <= 1'b0;
         EscReg    <= '0;
         WriteData <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         RegWrite <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  if (head_m2r) begin
                     state <= WAIT_MEM;
                  end else begin
                     RegWrite  <= head_rw && (head_rd != '0);
                     EscReg    <= head_rd;
                     WriteData <= head_alu;
                  end
               end
            end
            WAIT_MEM: begin
               if (mem_valid) begin
                  RegWrite  <= head_rw && (head_rd != '0);
                  EscReg    <= head_rd;
                  WriteData <= mem_rdata;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rd2_ext = ADDR_W'(hz_read2);

   // The registered write counts as pending until the bank latches it next edge.
   always_comb begin
      hz_off   = '0;
      hz_stall = RegWrite && ((EscReg == hz_read1) || (EscReg == rd2_ext));
      for (int i = 0; i < DEPTH; i++) begin
         hz_off = PTR_W'(i) - rd_ptr;
         if ((CNT_W'(hz_off) < count) && rw_q[i] && (rd_q[i] != '0) &&
             ((rd_q[i] == hz_read1) || (rd_q[i] == rd2_ext)))
            hz_stall = 1'b1;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic, all checked
// against a transaction-level queue model of the write-back stage.
module tb_writeback_stage;

   localparam int DEPTH = 2;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_rd;
   logic       in_reg_write;
   logic       in_mem_to_reg;
   logic [7:0] in_alu_result;
   logic       mem_valid;
   logic [7:0] mem_rdata;
   logic       RegWrite;
   logic [2:0] EscReg;
   logic [7:0] WriteData;
   logic [2:0] hz_read1;
   logic [1:0] hz_read2;
   logic       hz_stall;

   writeback_stage #(.DATA_W(8), .ADDR_W(3), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
      .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
      .in_alu_result(in_alu_result), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
      .RegWrite(RegWrite), .EscReg(EscReg), .WriteData(WriteData),
      .hz_read1(hz_read1), .hz_read2(hz_read2), .hz_stall(hz_stall)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] rd;
      logic       rw;
      logic       m2r;
      logic [7:0] alu;
   } ent_t;

   ent_t       mq[$];
   bit         m_wait;
   logic       m_we;
   logic [2:0] m_esc;
   logic [7:0] m_wd;
   int         n_cmp = 0;
   int         n_err = 0;
   int         n_writes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_hz(input logic [2:0] r1, input logic [1:0] r2);
      logic [2:0] r2e = {1'b0, r2};
      foreach (mq[i])
         if (mq[i].rw && mq[i].rd != 0 && (mq[i].rd == r1 || mq[i].rd == r2e)) return 1'b1;
      if (m_we && (m_esc == r1 || m_esc == r2e)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_reset();
      mq.delete();
      m_wait = 0;
      m_we   = 0;
      m_esc  = '0;
      m_wd   = '0;
   endfunction

   // One clock of the stage: commit from the head (in order), then accept at the tail.
   function automatic void model_step();
      ent_t h;
      bit   rdy = (mq.size() < DEPTH);
      m_we = 0;
      if (m_wait) begin
         if (mem_valid) begin
            h = mq.pop_front();
            m_we = h.rw && h.rd != 0;
            m_esc = h.rd;
            m_wd = mem_rdata;
            m_wait = 0;
         end
      end else if (mq.size() > 0) begin
         if (mq[0].m2r) m_wait = 1;
         else begin
            h = mq.pop_front();
            m_we = h.rw && h.rd != 0;
            m_esc = h.rd;
            m_wd = h.alu;
         end
      end
      if (in_valid && rdy) begin
         h.rd = in_rd; h.rw = in_reg_write; h.m2r = in_mem_to_reg; h.alu = in_alu_result;
         mq.push_back(h);
      end
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic cyc(input logic iv, input logic [2:0] rd, input logic rw, input logic m2r,
                      input logic [7:0] alu, input logic mv, input logic [7:0] md,
                      input logic [2:0] r1, input logic [1:0] r2);
      in_valid = iv; in_rd = rd; in_reg_write = rw; in_mem_to_reg = m2r;
      in_alu_result = alu; mem_valid = mv; mem_rdata = md;
      hz_read1 = r1; hz_read2 = r2;
      #1;
      chk("in_ready", in_ready, mq.size() < DEPTH);
      chk("hz_stall", hz_stall, model_hz(r1, r2));
      model_step();
      @(negedge clock);
      chk("RegWrite", RegWrite, m_we);
      chk("EscReg", EscReg, m_esc);
      chk("WriteData", WriteData, m_wd);
      if (RegWrite) n_writes++;
   endtask

   task automatic idle(input int n, input logic [2:0] r1, input logic [1:0] r2);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, r1, r2);
   endtask

   task automatic mid_reset();
      #2 reset_n = 0;
      in_valid = 0; mem_valid = 0;
      #1;
      chk("rst_RegWrite", RegWrite, 0);
      chk("rst_EscReg", EscReg, 0);
      chk("rst_WriteData", WriteData, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_hz_stall", hz_stall, 0);
      model_reset();
      @(negedge clock);
      reset_n = 1;
   endtask

   initial begin
      int w0;
      reset_n = 0;
      in_valid = 0; in_rd = 0; in_reg_write = 0; in_mem_to_reg = 0; in_alu_result = 0;
      mem_valid = 0; mem_rdata = 0; hz_read1 = 0; hz_read2 = 0;
      model_reset();
      #12;
      chk("por_RegWrite", RegWrite, 0);
      chk("por_in_ready", in_ready, 1);
      @(negedge clock);
      reset_n = 1;

      // ALU write rd3 <- 2A
      cyc(1, 3, 1, 0, 8'h2A, 0, 0, 3, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 3, 0);
      chk("alu_pulse", {RegWrite, EscReg, WriteData}, {1'b1, 3'd3, 8'h2A});
      idle(1, 3, 0);
      chk("alu_single", RegWrite, 0);

      // load rd5, data returns three cycles later; then a stray mem_valid
      w0 = n_writes;
      cyc(1, 5, 1, 1, 8'h77, 0, 0, 5, 0);
      idle(3, 5, 0);
      cyc(0, 0, 0, 0, 0, 1, 8'h1B, 5, 0);
      chk("load_data", {RegWrite, EscReg, WriteData}, {1'b1, 3'd5, 8'h1B});
      idle(1, 5, 0);
      cyc(0, 0, 0, 0, 0, 1, 8'hC3, 0, 0);
      idle(1, 0, 0);
      chk("load_writes", n_writes - w0, 1);

      // backpressure: two loads fill the FIFO, third request waits
      cyc(1, 1, 1, 1, 0, 0, 0, 1, 2'd2);
      cyc(1, 6, 1, 1, 0, 0, 0, 6, 2'd1);
      for (int i = 0; i < 3; i++) cyc(1, 7, 1, 0, 8'h5A, 0, 0, 7, 2'd1);
      chk("bp_full", in_ready, 0);
      cyc(0, 0, 0, 0, 0, 1, 8'h11, 1, 2'd2);
      cyc(0, 0, 0, 0, 0, 0, 0, 6, 2'd3);
      idle(2, 6, 0);
      cyc(0, 0, 0, 0, 0, 1, 8'h66, 6, 0);
      idle(3, 7, 0);

      // rd0 and reg_write=0 entries drain silently
      w0 = n_writes;
      cyc(1, 0, 1, 0, 8'hFF, 0, 0, 0, 0);
      cyc(1, 2, 0, 0, 8'h22, 0, 0, 2, 2'd2);
      idle(3, 2, 2'd2);
      chk("nowrite_cnt", n_writes - w0, 0);
      chk("nowrite_empty", in_ready, 1);

      // hazards: pending load to rd4, and hz_read2=3 against pending rd3
      cyc(1, 4, 1, 1, 0, 0, 0, 4, 0);
      idle(2, 4, 0);
      chk("hz_load", hz_stall, 1);
      cyc(1, 3, 1, 1, 0, 0, 0, 0, 2'd3);
      cyc(0, 0, 0, 0, 0, 1, 8'h44, 4, 2'd3);
      idle(1, 4, 0);
      idle(1, 0, 2'd3);
      chk("hz_read2", hz_stall, 1);
      cyc(0, 0, 0, 0, 0, 1, 8'h33, 0, 2'd3);
      idle(2, 0, 2'd3);

      // reset abandons a waiting load
      w0 = n_writes;
      cyc(1, 2, 1, 1, 0, 0, 0, 2, 0);
      idle(2, 2, 0);
      mid_reset();
      cyc(0, 0, 0, 0, 0, 1, 8'hEE, 2, 0);
      idle(2, 2, 0);
      chk("abort_nowrite", n_writes - w0, 0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if (i == 300) mid_reset();
         cyc(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 2) == 0),
             8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
